// File: rtl/rdata_chan_mngr.sv
// -----------------------------------------------------------------------------
// rdata_chan_mngr
//
// Manager-side AXI R-channel receiver. It collects one fixed 4-beat, 32-bit
// read burst and packs it into a 128-bit line, then presents that line with
// its ID to the refill consumer (I-cache / D-cache). The line is held until
// the consumer acknowledges it. Every burst is checked for rlast placement
// and for a consistent rid across all four beats.
//
// Ports
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   rvalid         in   R channel valid
//   rready         out  R channel ready (idle / receiving and not in reset)
//   rid   [3:0]    in   R channel transaction ID
//   rdata [31:0]   in   R channel data beat
//   rlast          in   R channel last-beat marker
//   rdata_m_valid  out  assembled line available (level)
//   rdata_m_id     out  ID latched from beat 0
//   rdata_m_data   out  assembled line, beat k in bits [32k+31:32k]
//   rdata_m_err    out  protocol error seen in this burst
//   rdata_m_ack    in   consumer takes the line (ignored unless line valid)
//
// State table
//   state | meaning
//   MIDLE | waiting for beat 0 of a burst
//   MRECV | beats 1..3 outstanding
//   MFULL | line complete, held until rdata_m_ack
//   MDEFO | dead state, left only by rst
// -----------------------------------------------------------------------------
module rdata_chan_mngr (
    input  logic         clk,
    input  logic         rst,
    input  logic         rvalid,
    output logic         rready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    output logic         rdata_m_valid,
    output logic [3:0]   rdata_m_id,
    output logic [127:0] rdata_m_data,
    output logic         rdata_m_err,
    input  logic         rdata_m_ack
);

    typedef enum logic [1:0] {
        MIDLE = 2'b00,
        MRECV = 2'b01,
        MFULL = 2'b10,
        MDEFO = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] beat_cntr;
    logic       recv_ok;
    logic       beat_acc;
    logic       last_beat;
    logic       last_bad;
    logic       id_bad;
    logic       beat_bad;
    logic       line_take;

    // Acceptance is derived from state and rst directly so that the
    // next-state logic never depends on its own rready output.
    assign recv_ok   = (state == MIDLE) || (state == MRECV);
    assign beat_acc  = rvalid && recv_ok && !rst;
    assign last_beat = (beat_cntr == 2'd3);
    assign line_take = (state == MFULL) && rdata_m_ack;

    // rlast must be high on beat 3 and only on beat 3; beats 1..3 must carry
    // the ID latched on beat 0.
    assign last_bad  = rlast ^ last_beat;
    assign id_bad    = (beat_cntr != 2'd0) && (rid != rdata_m_id);
    assign beat_bad  = last_bad || id_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MIDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rready        = 1'b0;
        rdata_m_valid = 1'b0;
        case (state)
            MIDLE: begin
                rready = !rst;
                if (beat_acc) begin
                    state_nxt = MRECV;
                end
            end
            MRECV: begin
                rready = !rst;
                if (beat_acc && last_beat) begin
                    state_nxt = MFULL;
                end
            end
            MFULL: begin
                rdata_m_valid = 1'b1;
                if (rdata_m_ack) begin
                    state_nxt = MIDLE;
                end
            end
            MDEFO: begin
                state_nxt = MDEFO;
            end
            default: begin
                state_nxt = MIDLE;
            end
        endcase
    end

    // Beat counter wraps 3 -> 0 on the final beat, so it is already 0 when
    // the FSM returns to MIDLE. Line bits not yet written in the current
    // burst keep their old contents; only the MFULL image matters.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cntr    <= 2'd0;
            rdata_m_data <= 128'd0;
            rdata_m_id   <= 4'd0;
            rdata_m_err  <= 1'b0;
        end else begin
            if (beat_acc) begin
                beat_cntr <= beat_cntr + 2'd1;
                rdata_m_data[{beat_cntr, 5'd0} +: 32] <= rdata;
                if (beat_cntr == 2'd0) begin
                    rdata_m_id  <= rid;
                    rdata_m_err <= beat_bad;
                end else begin
                    rdata_m_err <= rdata_m_err || beat_bad;
                end
            end else if (line_take) begin
                rdata_m_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rdata_chan_mngr.sv
module tb_rdata_chan_mngr;

    logic         clk = 1'b0;
    logic         rst;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rdata_m_valid;
    logic [3:0]   rdata_m_id;
    logic [127:0] rdata_m_data;
    logic         rdata_m_err;
    logic         rdata_m_ack;

    int checks = 0;
    int errors = 0;

    // current and next random bursts: ids packed 4x4, data 4x32, lasts 4x1, gaps 4x4
    logic [15:0]  cur_ids,   nxt_ids;
    logic [127:0] cur_d,     nxt_d;
    logic [3:0]   cur_lasts, nxt_lasts;
    logic [15:0]  cur_gaps,  nxt_gaps;
    bit           bp;

    always #5 clk = ~clk;

    rdata_chan_mngr dut (
        .clk           (clk),
        .rst           (rst),
        .rvalid        (rvalid),
        .rready        (rready),
        .rid           (rid),
        .rdata         (rdata),
        .rlast         (rlast),
        .rdata_m_valid (rdata_m_valid),
        .rdata_m_id    (rdata_m_id),
        .rdata_m_data  (rdata_m_data),
        .rdata_m_err   (rdata_m_err),
        .rdata_m_ack   (rdata_m_ack)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Error expectation straight from the burst rules: rlast only on beat 3,
    // same rid on every beat.
    function automatic logic burst_err(input logic [15:0] ids, input logic [3:0] lasts);
        logic e;
        e = (lasts != 4'b1000);
        for (int k = 1; k < 4; k++)
            if (ids[4*k +: 4] != ids[3:0]) e = 1'b1;
        return e;
    endfunction

    // Drives one burst starting at a negedge with the DUT idle, checks the
    // delivered line, holds it for 'hold' cycles, then acks (optional).
    // With bp set, beat 0 of the following burst is presented during the hold.
    task automatic run_burst(input string nm, input logic [15:0] ids, input logic [127:0] d,
                             input logic [3:0] lasts, input logic [15:0] gaps, input int hold,
                             input bit stray, input bit bpr, input logic [3:0] bp_id,
                             input logic [31:0] bp_d, input bit do_ack);
        logic e;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
                rvalid      = 1'b0;
                rdata_m_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                chk({nm, ":rdy_gap"}, rready, 1);
                chk({nm, ":vld_gap"}, rdata_m_valid, 0);
                tick;
            end
            rvalid      = 1'b1;
            rid         = ids[4*k +: 4];
            rdata       = d[32*k +: 32];
            rlast       = lasts[k];
            rdata_m_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            chk({nm, ":rdy_beat"}, rready, 1);
            chk({nm, ":vld_recv"}, rdata_m_valid, 0);
            tick;
        end
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rdata_m_ack = 1'b0;
        e = burst_err(ids, lasts);
        chk({nm, ":line_vld"}, rdata_m_valid, 1);
        chk({nm, ":line_data"}, rdata_m_data, d);
        chk({nm, ":line_id"}, rdata_m_id, ids[3:0]);
        chk({nm, ":line_err"}, rdata_m_err, e);
        chk({nm, ":rdy_full"}, rready, 0);
        if (bpr) begin
            rvalid = 1'b1;
            rid    = bp_id;
            rdata  = bp_d;
            rlast  = 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            tick;
            chk({nm, ":vld_hold"}, rdata_m_valid, 1);
            chk({nm, ":data_hold"}, rdata_m_data, d);
            chk({nm, ":id_hold"}, rdata_m_id, ids[3:0]);
            chk({nm, ":err_hold"}, rdata_m_err, e);
            chk({nm, ":rdy_hold"}, rready, 0);
        end
        if (do_ack) begin
            rdata_m_ack = 1'b1;
            tick;
            rdata_m_ack = 1'b0;
            chk({nm, ":vld_ack"}, rdata_m_valid, 0);
            chk({nm, ":rdy_ack"}, rready, 1);
        end
    endtask

    task automatic gen_burst(output logic [15:0] ids, output logic [127:0] d,
                             output logic [3:0] lasts, output logic [15:0] gaps);
        logic [3:0] base;
        int         k;
        base = 4'($urandom);
        ids  = {4{base}};
        d    = {$urandom, $urandom, $urandom, $urandom};
        lasts = 4'b1000;
        gaps = 16'd0;
        for (int j = 0; j < 4; j++) gaps[4*j +: 4] = 4'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 3);
            ids[4*k +: 4] = base ^ 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 3);
            lasts[k] = ~lasts[k];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        rvalid      = 1'b0;
        rid         = 4'd0;
        rdata       = 32'd0;
        rlast       = 1'b0;
        rdata_m_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:rdy", rready, 0);
        chk("rst:vld", rdata_m_valid, 0);
        chk("rst:data", rdata_m_data, 0);
        chk("rst:id", rdata_m_id, 0);
        chk("rst:err", rdata_m_err, 0);
        rst = 1'b0;
        #1;
        chk("rst:rdy_after", rready, 1);
        @(negedge clk);

        // clean burst
        run_burst("clean", {4{4'd5}}, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                  4'b1000, 16'h0000, 0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // 3-cycle gap before beat 2, ack held 5 cycles
        run_burst("gapped", {4{4'd7}}, {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000},
                  4'b1000, 16'h0300, 5, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // back-pressure: rid 9 burst presented while the previous line is held
        run_burst("bp_first", {4{4'd2}}, {32'h13, 32'h12, 32'h11, 32'h10},
                  4'b1000, 16'h0000, 4, 1'b0, 1'b1, 4'd9, 32'hA0, 1'b1);
        run_burst("bp_second", {4{4'd9}}, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                  4'b1000, 16'h0000, 1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // protocol errors
        run_burst("err_last1", {4{4'd4}}, {32'h4, 32'h3, 32'h2, 32'h1},
                  4'b1010, 16'h0000, 1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        run_burst("err_clear", {4{4'd4}}, {32'h8, 32'h7, 32'h6, 32'h5},
                  4'b1000, 16'h0000, 0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        run_burst("err_rid2", {4'd6, 4'd3, 4'd6, 4'd6}, {32'hC, 32'hB, 32'hA, 32'h9},
                  4'b1000, 16'h0000, 0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // stray acks in MIDLE and MRECV
        run_burst("stray", {4{4'd1}}, {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000},
                  4'b1000, 16'h2122, 2, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);

        // reset after two beats of a burst
        rvalid = 1'b1;
        rid    = 4'd3;
        rlast  = 1'b0;
        rdata  = 32'hDEAD0000;
        tick;
        rdata  = 32'hDEAD0001;
        tick;
        rvalid = 1'b0;
        rst    = 1'b1;
        #1;
        chk("midrst:rdy_in_rst", rready, 0);
        tick;
        chk("midrst:vld", rdata_m_valid, 0);
        chk("midrst:data", rdata_m_data, 0);
        chk("midrst:id", rdata_m_id, 0);
        chk("midrst:err", rdata_m_err, 0);
        chk("midrst:rdy", rready, 0);
        rst = 1'b0;
        #1;
        chk("midrst:rdy_after", rready, 1);
        run_burst("after_rst", {4{4'd11}}, {32'hB3, 32'hB2, 32'hB1, 32'hB0},
                  4'b1000, 16'h0000, 0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // reset while the line is held: dropped without ack
        run_burst("full_rst", {4{4'd12}}, {32'hF3, 32'hF2, 32'hF1, 32'hF0},
                  4'b1000, 16'h0000, 2, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        rst = 1'b1;
        tick;
        chk("full_rst:vld", rdata_m_valid, 0);
        chk("full_rst:data", rdata_m_data, 0);
        rst = 1'b0;
        #1;
        chk("full_rst:rdy_after", rready, 1);
        @(negedge clk);

        // randomized bursts
        gen_burst(cur_ids, cur_d, cur_lasts, cur_gaps);
        for (int i = 0; i < 30; i++) begin
            gen_burst(nxt_ids, nxt_d, nxt_lasts, nxt_gaps);
            bp = (i != 29) && ($urandom_range(0, 1) == 1);
            if (bp) begin
                nxt_gaps[3:0] = 4'd0;
                nxt_lasts[0]  = 1'b0;
            end
            run_burst("rand", cur_ids, cur_d, cur_lasts, cur_gaps, $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), bp, nxt_ids[3:0], nxt_d[31:0], 1'b1);
            cur_ids   = nxt_ids;
            cur_d     = nxt_d;
            cur_lasts = nxt_lasts;
            cur_gaps  = nxt_gaps;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
